// File: rtl/pcache_param_writer_if.sv
// pcache_param_writer_if: start/stream handshake and the assembled record fields of the parameter writer.
// PCACHE_UV16_EN adds the uv16 request flag.
interface pcache_param_writer_if #(parameter int TAG_W = 10);
  logic             start;
  logic [TAG_W-1:0] prim_tag_in;
  logic             textured;
  logic             offset;
`ifdef PCACHE_UV16_EN
  logic             uv16;
`endif
  logic [31:0]      word_in;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic [TAG_W-1:0] prim_tag;
  logic             pcache_write;
  logic [31:0]      isp_inst_out, tsp_inst_out, tcw_word_out;
  logic [31:0]      vert_a_x_out, vert_a_y_out, vert_a_z_out, vert_a_u0_out, vert_a_v0_out,
                    vert_a_base_col_0_out, vert_a_off_col_out;
  logic [31:0]      vert_b_x_out, vert_b_y_out, vert_b_z_out, vert_b_u0_out, vert_b_v0_out,
                    vert_b_base_col_0_out, vert_b_off_col_out;
  logic [31:0]      vert_c_x_out, vert_c_y_out, vert_c_z_out, vert_c_u0_out, vert_c_v0_out,
                    vert_c_base_col_0_out, vert_c_off_col_out;

  modport master (
    output start, prim_tag_in, textured, offset, word_in, word_valid,
`ifdef PCACHE_UV16_EN
    output uv16,
`endif
    input  word_ready, busy, prim_tag, pcache_write, isp_inst_out, tsp_inst_out, tcw_word_out,
    input  vert_a_x_out, vert_a_y_out, vert_a_z_out, vert_a_u0_out, vert_a_v0_out,
           vert_a_base_col_0_out, vert_a_off_col_out,
    input  vert_b_x_out, vert_b_y_out, vert_b_z_out, vert_b_u0_out, vert_b_v0_out,
           vert_b_base_col_0_out, vert_b_off_col_out,
    input  vert_c_x_out, vert_c_y_out, vert_c_z_out, vert_c_u0_out, vert_c_v0_out,
           vert_c_base_col_0_out, vert_c_off_col_out
  );

  modport slave (
    input  start, prim_tag_in, textured, offset, word_in, word_valid,
`ifdef PCACHE_UV16_EN
    input  uv16,
`endif
    output word_ready, busy, prim_tag, pcache_write, isp_inst_out, tsp_inst_out, tcw_word_out,
    output vert_a_x_out, vert_a_y_out, vert_a_z_out, vert_a_u0_out, vert_a_v0_out,
           vert_a_base_col_0_out, vert_a_off_col_out,
    output vert_b_x_out, vert_b_y_out, vert_b_z_out, vert_b_u0_out, vert_b_v0_out,
           vert_b_base_col_0_out, vert_b_off_col_out,
    output vert_c_x_out, vert_c_y_out, vert_c_z_out, vert_c_u0_out, vert_c_v0_out,
           vert_c_base_col_0_out, vert_c_off_col_out
  );
endinterface

// File: rtl/pcache_param_writer.sv
// pcache_param_writer: assembles one triangle's parameter word stream into a single primitive cache write.
// Optional PCACHE_UV16_EN: a textured vertex may carry one packed 16-bit U/V word instead of two.
module pcache_param_writer #(
  parameter int TAG_W = 10
) (
  input logic                  clock,
  input logic                  reset_n,
  pcache_param_writer_if.slave pc
);
  typedef enum logic [1:0] {IDLE, HDR, VERT, WRITE} state_t;
  state_t           state_q, state_d;
  logic [1:0]       vtx_q, vtx_d;
  logic [2:0]       wrd_q, wrd_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             tex_q, tex_d, ofs_q, ofs_d, uv16_q;
  // Record layout: 0 ISP, 1 TSP, 2 TCW, then per vertex 3+7v: x y z u0 v0 base off
  logic [31:0]      fld_q [24];
  logic [31:0]      fld_d [24];
  logic             acc, last, pk;
  logic [1:0]       uvn;
  logic [2:0]       slot;
  logic [4:0]       idx;

`ifdef PCACHE_UV16_EN
  logic uv16_d;
  assign uv16_d = (state_q == IDLE && pc.start) ? pc.uv16 : uv16_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) uv16_q <= 1'b0;
    else          uv16_q <= uv16_d;
`else
  assign uv16_q = 1'b0;
`endif

  assign pc.word_ready   = state_q == HDR || state_q == VERT;
  assign pc.busy         = state_q != IDLE;
  assign pc.pcache_write = state_q == WRITE;
  assign pc.prim_tag     = tag_q;
  assign acc  = pc.word_valid & pc.word_ready;
  // Words after the U/V group shift up to the base/offset slots when fewer U/V words are present
  assign uvn  = tex_q ? (uv16_q ? 2'd1 : 2'd2) : 2'd0;
  assign slot = (wrd_q >= 3'd3 + {1'b0, uvn}) ? wrd_q + 3'd2 - {1'b0, uvn} : wrd_q;
  assign last = wrd_q == 3'd3 + {1'b0, uvn} + {2'b0, ofs_q};
  assign pk   = tex_q & uv16_q & (wrd_q == 3'd3);
  assign idx  = 5'd3 + 5'd7 * {3'b0, vtx_q} + {2'b0, slot};

  always_comb begin
    state_d = state_q;
    vtx_d   = vtx_q;
    wrd_d   = wrd_q;
    tag_d   = tag_q;
    tex_d   = tex_q;
    ofs_d   = ofs_q;
    fld_d   = fld_q;
    case (state_q)
      IDLE: if (pc.start) begin
        state_d = HDR;
        tag_d   = pc.prim_tag_in;
        tex_d   = pc.textured;
        ofs_d   = pc.offset;
        vtx_d   = 2'd0;
        wrd_d   = 3'd0;
        fld_d   = '{default: '0};
      end
      HDR: if (acc) begin
        fld_d[{2'b0, wrd_q}] = pc.word_in;
        wrd_d   = wrd_q == 3'd2 ? 3'd0 : wrd_q + 3'd1;
        state_d = wrd_q == 3'd2 ? VERT : HDR;
      end
      VERT: if (acc) begin
        if (pk) begin
          fld_d[idx]        = {pc.word_in[31:16], 16'h0};
          fld_d[idx + 5'd1] = {pc.word_in[15:0], 16'h0};
        end else begin
          fld_d[idx] = pc.word_in;
        end
        wrd_d   = last ? 3'd0 : wrd_q + 3'd1;
        vtx_d   = last ? vtx_q + 2'd1 : vtx_q;
        state_d = (last && vtx_q == 2'd2) ? WRITE : VERT;
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      vtx_q   <= 2'd0;
      wrd_q   <= 3'd0;
      tag_q   <= '0;
      tex_q   <= 1'b0;
      ofs_q   <= 1'b0;
      fld_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      vtx_q   <= vtx_d;
      wrd_q   <= wrd_d;
      tag_q   <= tag_d;
      tex_q   <= tex_d;
      ofs_q   <= ofs_d;
      fld_q   <= fld_d;
    end

  assign pc.isp_inst_out          = fld_q[0];
  assign pc.tsp_inst_out          = fld_q[1];
  assign pc.tcw_word_out          = fld_q[2];
  assign pc.vert_a_x_out          = fld_q[3];
  assign pc.vert_a_y_out          = fld_q[4];
  assign pc.vert_a_z_out          = fld_q[5];
  assign pc.vert_a_u0_out         = fld_q[6];
  assign pc.vert_a_v0_out         = fld_q[7];
  assign pc.vert_a_base_col_0_out = fld_q[8];
  assign pc.vert_a_off_col_out    = fld_q[9];
  assign pc.vert_b_x_out          = fld_q[10];
  assign pc.vert_b_y_out          = fld_q[11];
  assign pc.vert_b_z_out          = fld_q[12];
  assign pc.vert_b_u0_out         = fld_q[13];
  assign pc.vert_b_v0_out         = fld_q[14];
  assign pc.vert_b_base_col_0_out = fld_q[15];
  assign pc.vert_b_off_col_out    = fld_q[16];
  assign pc.vert_c_x_out          = fld_q[17];
  assign pc.vert_c_y_out          = fld_q[18];
  assign pc.vert_c_z_out          = fld_q[19];
  assign pc.vert_c_u0_out         = fld_q[20];
  assign pc.vert_c_v0_out         = fld_q[21];
  assign pc.vert_c_base_col_0_out = fld_q[22];
  assign pc.vert_c_off_col_out    = fld_q[23];
endmodule

// File: tb/tb_pcache_param_writer.sv
// tb_pcache_param_writer: directed primitives checked against a scoreboard of expected cache records.
// Define PCACHE_UV16_EN to add the packed-UV primitive.
module tb_pcache_param_writer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  logic [31:0] obs [24];

  typedef struct {
    logic [9:0]        tag;
    logic [23:0][31:0] f;
    int                lat;
  } rec_t;
  rec_t sb[$];

  pcache_param_writer_if #(.TAG_W(10)) pc();
  pcache_param_writer #(.TAG_W(10)) dut (.clock(clock), .reset_n(reset_n), .pc(pc));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (pc.pcache_write) wr_cnt <= wr_cnt + 1;

  assign obs[0]  = pc.isp_inst_out;
  assign obs[1]  = pc.tsp_inst_out;
  assign obs[2]  = pc.tcw_word_out;
  assign obs[3]  = pc.vert_a_x_out;
  assign obs[4]  = pc.vert_a_y_out;
  assign obs[5]  = pc.vert_a_z_out;
  assign obs[6]  = pc.vert_a_u0_out;
  assign obs[7]  = pc.vert_a_v0_out;
  assign obs[8]  = pc.vert_a_base_col_0_out;
  assign obs[9]  = pc.vert_a_off_col_out;
  assign obs[10] = pc.vert_b_x_out;
  assign obs[11] = pc.vert_b_y_out;
  assign obs[12] = pc.vert_b_z_out;
  assign obs[13] = pc.vert_b_u0_out;
  assign obs[14] = pc.vert_b_v0_out;
  assign obs[15] = pc.vert_b_base_col_0_out;
  assign obs[16] = pc.vert_b_off_col_out;
  assign obs[17] = pc.vert_c_x_out;
  assign obs[18] = pc.vert_c_y_out;
  assign obs[19] = pc.vert_c_z_out;
  assign obs[20] = pc.vert_c_u0_out;
  assign obs[21] = pc.vert_c_v0_out;
  assign obs[22] = pc.vert_c_base_col_0_out;
  assign obs[23] = pc.vert_c_off_col_out;

  task automatic chk(input string nm, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", nm, o, e);
    end
  endtask

  // Drives one primitive; limit < word count aborts the stream, poke re-pulses start at that word index.
  task automatic prim(input logic [9:0] tag, input bit tex, input bit ofs, input bit uv,
                      input logic [31:0] base, input bit tog, input int limit, input int poke);
    rec_t r;
    logic [31:0] s[$];
    logic [31:0] w;
    int k, st, i, g, n;
    r.tag = tag;
    r.f   = '0;
    k = 0;
    for (int h = 0; h < 3; h++) begin w = base + k; k++; s.push_back(w); r.f[h] = w; end
    for (int v = 0; v < 3; v++) begin
      int b = 3 + 7 * v;
      for (int j = 0; j < 3; j++) begin w = base + k; k++; s.push_back(w); r.f[b + j] = w; end
      if (tex && uv) begin
        w = 32'h3F804000; k++; s.push_back(w);
        r.f[b + 3] = {w[31:16], 16'h0};
        r.f[b + 4] = {w[15:0], 16'h0};
      end else if (tex) begin
        w = base + k; k++; s.push_back(w); r.f[b + 3] = w;
        w = base + k; k++; s.push_back(w); r.f[b + 4] = w;
      end
      w = base + k; k++; s.push_back(w); r.f[b + 5] = w;
      if (ofs) begin w = base + k; k++; s.push_back(w); r.f[b + 6] = w; end
    end
    n = s.size();
    r.lat = tog ? 2 * n : n + 1;
    if (limit >= n) sb.push_back(r);
    @(negedge clock);
    pc.start = 1'b1; pc.prim_tag_in = tag; pc.textured = tex; pc.offset = ofs;
`ifdef PCACHE_UV16_EN
    pc.uv16 = uv;
`endif
    st = cyc;
    i = 0; g = 0;
    while (i < n && i < limit && g < 200) begin
      @(negedge clock);
      g++;
      pc.start = (i == poke);
      if (i == poke) begin pc.prim_tag_in = ~tag; pc.textured = ~tex; pc.offset = ~ofs; end
      pc.word_valid = !tog || (g % 2 == 1);
      pc.word_in    = pc.word_valid ? s[i] : 32'hDEADBEEF;
      if (pc.word_valid && pc.word_ready) i++;
    end
    chk("words_accepted", i, (n < limit) ? n : limit);
    if (limit >= n) begin
      g = 0;
      do begin @(negedge clock); pc.word_valid = 1'b0; pc.start = 1'b0; g++; end
      while (!pc.pcache_write && g < 10);
      chk("write_seen", pc.pcache_write, 1);
      if (pc.pcache_write && sb.size() > 0) begin
        r = sb.pop_front();
        chk("write_latency", cyc - st, r.lat);
        chk("prim_tag", pc.prim_tag, r.tag);
        chk("busy_in_write", pc.busy, 1);
        chk("ready_in_write", pc.word_ready, 0);
        for (int j = 0; j < 24; j++) chk($sformatf("field%0d", j), obs[j], r.f[j]);
      end
      @(negedge clock);
      chk("write_single_cycle", pc.pcache_write, 0);
      chk("busy_fall", pc.busy, 0);
    end
  endtask

  initial begin
    int wc;
    pc.start = 0; pc.prim_tag_in = 0; pc.textured = 0; pc.offset = 0;
    pc.word_in = 0; pc.word_valid = 0;
`ifdef PCACHE_UV16_EN
    pc.uv16 = 0;
`endif
    #12;
    chk("rst_busy", pc.busy, 0);
    chk("rst_ready", pc.word_ready, 0);
    chk("rst_write", pc.pcache_write, 0);
    chk("rst_tag", pc.prim_tag, 0);
    chk("rst_isp", obs[0], 0);
    chk("rst_c_off", obs[23], 0);
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    chk("idle_ready", pc.word_ready, 0);

    wc = wr_cnt;
    prim(10'h005, 0, 0, 0, 32'h100, 0, 99, -1);
    chk("t1_isp", obs[0], 32'h100);
    chk("t1_a_x", obs[3], 32'h103);
    chk("t1_c_base", obs[22], 32'h10E);
    chk("t1_a_u0", obs[6], 0);
    chk("t1_c_off", obs[23], 0);
    chk("t1_pulses", wr_cnt - wc, 1);

    wc = wr_cnt;
    prim(10'h3FF, 1, 1, 0, 32'h200, 0, 99, -1);
    chk("t2_a_u0", obs[6], 32'h206);
    chk("t2_b_off", obs[16], 32'h210);
    chk("t2_c_off", obs[23], 32'h217);
    chk("t2_pulses", wr_cnt - wc, 1);

    wc = wr_cnt;
    prim(10'h3FF, 1, 1, 0, 32'h200, 1, 99, -1);
    chk("t3_b_off", obs[16], 32'h210);
    chk("t3_pulses", wr_cnt - wc, 1);

    wc = wr_cnt;
    prim(10'h123, 1, 0, 0, 32'h500, 0, 99, 12);
    chk("t4_pulses", wr_cnt - wc, 1);

    wc = wr_cnt;
    prim(10'h155, 1, 1, 0, 32'h300, 0, 10, -1);
    @(negedge clock);
    pc.word_valid = 1'b0; reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", pc.busy, 0);
    chk("mid_rst_ready", pc.word_ready, 0);
    chk("mid_rst_tag", pc.prim_tag, 0);
    for (int j = 0; j < 24; j++) chk($sformatf("mid_rst_field%0d", j), obs[j], 0);
    @(negedge clock); reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("mid_rst_no_write", wr_cnt - wc, 0);
    prim(10'h0AA, 0, 0, 0, 32'h400, 0, 99, -1);
    chk("t5_pulses", wr_cnt - wc, 1);

`ifdef PCACHE_UV16_EN
    prim(10'h002, 1, 0, 1, 32'h600, 0, 99, -1);
    chk("uv_a_u0", obs[6], 32'h3F800000);
    chk("uv_a_v0", obs[7], 32'h40000000);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pcache_param_writer.md
# pcache_param_writer

Fill side of the PVR primitive parameter cache. Accepts a 32-bit word stream of one triangle's ISP/TSP parameters fetched from VRAM. Assembles the ISP instruction, TSP instruction, TCW and three vertices (X, Y, Z, U0, V0, base colour, offset colour) into registered field outputs. Then issues a single-cycle `pcache_write` with the primitive's tag, so the cache stores the full record in one write.

## Interface
Parameters:
- `TAG_W`, 10: primitive tag width; matches the cache's 1024 entries.

Ports:
- `clock`  in  1  sole clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a primitive; sampled only in IDLE.
- `prim_tag_in`  in  TAG_W  tag for this primitive; latched on accepted `start`.
- `textured`  in  1  U/V words present per vertex; latched on `start`.
- `offset`  in  1  offset-colour word present per vertex; latched on `start`.
- `word_in`  in  32  parameter stream data.
- `word_valid`  in  1  `word_in` is valid.
- `word_ready`  out  1  the block accepts a word this cycle.
- `busy`  out  1  high from the accepted `start` through the write cycle.
- `prim_tag`  out  TAG_W  latched tag; drives the cache address.
- `pcache_write`  out  1  single-cycle write strobe.
- `isp_inst_out`, `tsp_inst_out`, `tcw_word_out`  out  32 each  registered header fields.
- `vert_{a,b,c}_{x,y,z,u0,v0,base_col_0,off_col}_out`  out  32 each  registered vertex fields (21 ports).

## Operation
- States: IDLE, HDR, VERT, WRITE.
- IDLE:
  - `start`=1 latches the tag and flags.
  - Clears every field output to 0, so absent U/V/offset fields store 0.
  - Vertex index set to A, word index to 0; next state HDR.
- HDR: accepts 3 words, in order ISP, TSP, TCW. TCW is always present, including for untextured primitives. Next state VERT.
- VERT, per vertex in order A, B, C:
  - Word order is X, Y, Z, [U0, V0 if textured], base_col, [off_col if offset].
  - Words per vertex = 4 + 2·textured + offset.
  - After the last word of C, next state WRITE.
- WRITE: `pcache_write`=1 for exactly one cycle; next state IDLE.
- Total words per primitive: 15 (no texture, no offset), 18, 21, or 24 (textured with offset).
- A word is consumed only when `word_valid & word_ready`. Stalls with `word_valid`=0 are unbounded and leave state unchanged.
- `start` outside IDLE is ignored. No queuing.
- Reset mid-primitive: return to IDLE with no write issued, and all outputs return to their reset values.

## Timing
- Reset values: all outputs 0, including `word_ready`, `busy` and `pcache_write`. State is IDLE.
- Cycle 0: `start` accepted.
- From cycle 1: `word_ready`=1 throughout HDR/VERT, so at most one word is accepted per cycle.
- Each field register updates on the edge where its word is accepted.
- With back-to-back valid words the last word is accepted at cycle N. `pcache_write`=1 at cycle N+1, with all fields and `prim_tag` stable and final.
- `busy` falls at cycle N+2. A new `start` is accepted no earlier than cycle N+2, so the minimum period is N+2 cycles.
- `word_ready`=0 in IDLE and WRITE.

## Configuration
- `PCACHE_UV16_EN` defined:
  - Adds input `uv16` (1 bit, latched on `start`).
  - When `textured` and `uv16` are both 1, each vertex carries one packed UV word in place of U0 and V0.
  - `u0_out` = {word[31:16], 16'h0}; `v0_out` = {word[15:0], 16'h0}.
  - Words per vertex = 4 + textured·(uv16 ? 1 : 2) + offset.
- `PCACHE_UV16_EN` undefined: the port is absent and U/V are always two full words.

## Test plan
- Untextured, no offset, tag 0x005, 15 back-to-back words 0x100..0x10E:
  - One `pcache_write` pulse, 16 cycles after `start`, with `prim_tag`=0x005.
  - `isp_inst_out`=0x100, `vert_a_x_out`=0x103, `vert_c_base_col_0_out`=0x10E.
  - All U/V and offset outputs 0.
- Textured with offset, tag 0x3FF, 24 words 0x200..0x217:
  - `vert_a_u0_out`=0x206, `vert_b_off_col_out`=0x210, `vert_c_off_col_out`=0x217.
  - Exactly one write pulse.
- Same stream as above with `word_valid` toggled 1/0 every cycle:
  - Identical field values.
  - Write pulse 48 cycles after `start`.
- `start` pulsed during VERT: no effect, and the in-flight primitive completes with its original tag and flags.
- `reset_n` asserted after 10 of 24 words:
  - Outputs return to 0 and no `pcache_write` occurs.
  - A following 15-word primitive writes correctly.
- With `PCACHE_UV16_EN`, textured, `uv16`=1, UV word 0x3F804000:
  - `u0_out`=0x3F800000, `v0_out`=0x40000000.
  - 18-word primitive with no offset.
